// File: rtl/drive_source_mux_pkg.sv
// rtl/drive_source_mux_pkg.sv - FSM state type and saturating limit arithmetic for drive_source_mux
package drive_source_mux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        SWAP = 2'd2,
        UP   = 2'd3
    } state_t;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a <= b) ? 32'd0 : a - b;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_v);
        return (max_v - a <= b) ? max_v : a + b;
    endfunction

endpackage

// File: rtl/drive_source_mux_sync_boundary_det.sv
// rtl/drive_source_mux_sync_boundary_det.sv - one-cycle pulse on each toggle of a system-time bit
module sync_boundary_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_time_bit,
    output logic o_bnd
);

    logic r_prev_bit;

    // Tracks the bit during reset too, so leaving reset never looks like a toggle.
    always_ff @(posedge i_clk) begin
        r_prev_bit <= i_time_bit;
    end

    assign o_bnd = !i_rst && (i_time_bit ^ r_prev_bit);

endmodule

// File: rtl/drive_source_mux.sv
// rtl/drive_source_mux.sv - per-array drive source select with time-aligned, optionally ramped switching
module drive_source_mux
    import drive_source_mux_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int DEPTH       = 249,
    parameter int N_SRC       = 4,
    parameter int ALIGN_BITS  = 8,
    parameter int DEFAULT_SRC = 0,
    localparam int SEL_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [63:0]                              i_sys_time,
    input  logic [N_SRC-1:0][DEPTH-1:0][WIDTH-1:0]   i_src_duty,
    input  logic [N_SRC-1:0][DEPTH-1:0][WIDTH-1:0]   i_src_phase,
    input  logic [N_SRC-1:0]                         i_src_en,
    input  logic [SEL_W-1:0]                         i_sel_req,
    input  logic                                     i_req_valid,
    output logic                                     o_req_ready,
    input  logic [WIDTH-1:0]                         i_ramp_step,
    output logic [DEPTH-1:0][WIDTH-1:0]              o_duty_out,
    output logic [DEPTH-1:0][WIDTH-1:0]              o_phase_out,
    output logic [SEL_W-1:0]                         o_cur_sel,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err
);

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t             r_state;
    logic [SEL_W-1:0]   r_cur_sel;
    logic [SEL_W-1:0]   r_pend;
    logic [WIDTH-1:0]   r_step;
    logic [WIDTH-1:0]   r_limit;
    logic               r_done;
    logic               r_err;

    logic               w_bnd;
    logic               w_req_ok;
    logic               w_cur_en;
    logic [WIDTH-1:0]   w_lim_dn;
    logic [WIDTH-1:0]   w_lim_up;
    logic               w_time_unused;

    sync_boundary_det u_bnd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_time_bit (i_sys_time[ALIGN_BITS]),
        .o_bnd      (w_bnd)
    );

    assign w_time_unused = ^i_sys_time;

    assign w_req_ok = (32'(i_sel_req) < N_SRC) && i_src_en[i_sel_req];
    assign w_cur_en = i_src_en[r_cur_sel];
    assign w_lim_dn = WIDTH'(sat_sub(32'(r_limit), 32'(r_step)));
    assign w_lim_up = WIDTH'(sat_add(32'(r_limit), 32'(r_step), 32'(MAX)));

    // Requests are only taken in IDLE; a boundary in the accept cycle is deliberately ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cur_sel <= SEL_W'(DEFAULT_SRC);
            r_pend    <= SEL_W'(DEFAULT_SRC);
            r_step    <= '0;
            r_limit   <= MAX;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_pend <= i_sel_req;
                        r_step <= i_ramp_step;
                        if (!w_req_ok) begin
                            r_err <= 1'b1;
                        end else if (i_sel_req == r_cur_sel) begin
                            r_done <= 1'b1;
                        end else if (i_ramp_step == '0) begin
                            r_state <= SWAP;
                        end else begin
                            r_state <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    if (w_bnd) begin
                        r_limit <= w_lim_dn;
                        if (w_lim_dn == '0) begin
                            r_state <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    if (w_bnd) begin
                        r_cur_sel <= r_pend;
                        if (r_step == '0) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= UP;
                        end
                    end
                end
                UP: begin
                    if (w_bnd) begin
                        r_limit <= w_lim_up;
                        if (w_lim_up == MAX) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A disabled active source silences duty but leaves phase where it was.
    for (genvar g = 0; g < DEPTH; g++) begin : g_lane
        logic [WIDTH-1:0] w_duty_src;
        logic [WIDTH-1:0] r_duty_lane;
        logic [WIDTH-1:0] r_phase_lane;

        assign w_duty_src = i_src_duty[r_cur_sel][g];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_duty_lane  <= '0;
                r_phase_lane <= '0;
            end else if (w_cur_en) begin
                r_duty_lane  <= (w_duty_src < r_limit) ? w_duty_src : r_limit;
                r_phase_lane <= i_src_phase[r_cur_sel][g];
            end else begin
                r_duty_lane  <= '0;
            end
        end

        assign o_duty_out[g]  = r_duty_lane;
        assign o_phase_out[g] = r_phase_lane;
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_cur_sel   = r_cur_sel;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_drive_source_mux.sv
// tb/tb_drive_source_mux.sv - scoreboard bench for drive_source_mux
module tb_drive_source_mux;

    localparam int WIDTH = 13;
    localparam int DEPTH = 249;
    localparam int N_SRC = 4;
    localparam int MAXV  = 8191;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                   rst;
    logic [63:0]                            sys_time;
    logic [N_SRC-1:0][DEPTH-1:0][WIDTH-1:0] src_duty;
    logic [N_SRC-1:0][DEPTH-1:0][WIDTH-1:0] src_phase;
    logic [N_SRC-1:0]                       src_en;
    logic [1:0]                             sel_req;
    logic                                   req_valid;
    logic                                   req_ready;
    logic [WIDTH-1:0]                       ramp_step;
    logic [DEPTH-1:0][WIDTH-1:0]            duty_out;
    logic [DEPTH-1:0][WIDTH-1:0]            phase_out;
    logic [1:0]                             cur_sel;
    logic                                   busy;
    logic                                   done;
    logic                                   err;

    drive_source_mux dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sys_time  (sys_time),
        .i_src_duty  (src_duty),
        .i_src_phase (src_phase),
        .i_src_en    (src_en),
        .i_sel_req   (sel_req),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_ramp_step (ramp_step),
        .o_duty_out  (duty_out),
        .o_phase_out (phase_out),
        .o_cur_sel   (cur_sel),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    typedef struct {
        bit is_err;
        int sel;
    } ev_t;

    ev_t ev_q[$];
    int  dq[$];
    int  n_chk = 0;
    int  n_err = 0;
    bit  m_on = 0;
    bit  time_run = 0;
    int  m_cur = 0;
    int  m_exp_last = 0;
    int  last_duty = 0;
    logic [DEPTH-1:0][WIDTH-1:0] m_ph;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s actual=expired expected=event", name);
    endtask

    function automatic int lane0(input int s, input int lim);
        int v;
        v = int'(src_duty[s][0]);
        if (!src_en[s]) return 0;
        return (v < lim) ? v : lim;
    endfunction

    task automatic push_duty(input int v);
        if (v != m_exp_last) begin
            dq.push_back(v);
            m_exp_last = v;
        end
    endtask

    initial begin
        sys_time = '0;
        forever begin
            @(negedge clk);
            if (time_run) sys_time = sys_time + 64'd1;
        end
    end

    // Monitor: pops expected events on DONE/ERR, expected lane-0 levels on each duty change.
    always @(negedge clk) begin
        ev_t e;
        if (done || err) begin
            if (ev_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_event actual=done%0d_err%0d expected=none", done, err);
            end else begin
                e = ev_q.pop_front();
                chk("ev_kind", {62'd0, done, err}, e.is_err ? 64'd1 : 64'd2);
                chk("ev_cur_sel", 64'(cur_sel), 64'(e.sel));
                chk("ev_busy", 64'(busy), 64'd0);
            end
        end
        if (int'(duty_out[0]) != last_duty) begin
            if (m_on) begin
                if (dq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_duty actual=%0d expected=unchanged_%0d",
                             duty_out[0], last_duty);
                end else begin
                    chk("duty_step", 64'(duty_out[0]), 64'(dq.pop_front()));
                end
            end
            last_duty = int'(duty_out[0]);
        end
    end

    task automatic full_check();
        int bad_d, bad_p;
        logic [WIDTH-1:0] ed, bd_exp, bp_exp;
        if (src_en[m_cur]) m_ph = src_phase[m_cur];
        bad_d = -1;
        bad_p = -1;
        bd_exp = '0;
        bp_exp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ed = src_en[m_cur] ? src_duty[m_cur][i] : '0;
            if (bad_d < 0 && duty_out[i] !== ed) begin bad_d = i; bd_exp = ed; end
            if (bad_p < 0 && phase_out[i] !== m_ph[i]) begin bad_p = i; bp_exp = m_ph[i]; end
        end
        n_chk++;
        if (bad_d >= 0) begin
            n_err++;
            $display("FAIL lanes_duty lane=%0d actual=%0d expected=%0d", bad_d, duty_out[bad_d], bd_exp);
        end
        n_chk++;
        if (bad_p >= 0) begin
            n_err++;
            $display("FAIL lanes_phase lane=%0d actual=%0d expected=%0d", bad_p, phase_out[bad_p], bp_exp);
        end
        chk("idle_cur_sel", 64'(cur_sel), 64'(m_cur));
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic wait_settle();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (ev_q.size() == 0 && dq.size() == 0 && req_ready) break;
        end
        if (k == 5000) begin
            fail_now("settle_timeout");
            ev_q.delete();
            dq.delete();
            m_exp_last = int'(duty_out[0]);
        end
        repeat (2) @(negedge clk);
        full_check();
    endtask

    task automatic wait_time(input logic [63:0] t);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(posedge clk);
            if (sys_time == t) break;
        end
        if (k == 4000) fail_now("sys_time_wait");
    endtask

    task automatic do_request(input int sel, input int step, input bit poke);
        bit quick;
        int lim;
        quick = !src_en[sel] || (sel == m_cur);
        if (!src_en[sel]) begin
            ev_q.push_back('{1'b1, m_cur});
        end else if (sel == m_cur) begin
            ev_q.push_back('{1'b0, m_cur});
        end else begin
            lim = MAXV;
            while (step != 0 && lim > 0) begin
                lim = (lim <= step) ? 0 : lim - step;
                push_duty(lane0(m_cur, lim));
            end
            push_duty(lane0(sel, lim));
            while (step != 0 && lim < MAXV) begin
                lim = (MAXV - lim <= step) ? MAXV : lim + step;
                push_duty(lane0(sel, lim));
            end
            ev_q.push_back('{1'b0, sel});
            m_cur = sel;
        end
        @(negedge clk);
        chk("ready_at_req", 64'(req_ready), 64'd1);
        sel_req   = 2'(sel);
        ramp_step = WIDTH'(step);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (quick) chk("quick_pulse", 64'(done | err), 64'd1);
        if (poke && !quick) begin
            repeat (3) @(negedge clk);
            if (busy) begin
                sel_req   = 2'($urandom_range(0, 3));
                ramp_step = WIDTH'($urandom_range(0, MAXV));
                req_valid = 1'b1;
                @(negedge clk);
                req_valid = 1'b0;
            end
        end
        wait_settle();
    endtask

    task automatic new_scenario();
        for (int s = 0; s < N_SRC; s++)
            for (int i = 0; i < DEPTH; i++) begin
                src_duty[s][i]  = WIDTH'($urandom_range(0, MAXV));
                src_phase[s][i] = WIDTH'($urandom_range(0, MAXV));
            end
        src_en = 4'($urandom_range(1, 15));
        push_duty(lane0(m_cur, MAXV));
        wait_settle();
    endtask

    initial begin
        int k, sel, step;
        rst = 1'b1;
        req_valid = 1'b0;
        sel_req = '0;
        ramp_step = '0;
        src_en = 4'hF;
        m_ph = '0;
        for (int s = 0; s < N_SRC; s++)
            for (int i = 0; i < DEPTH; i++) begin
                src_duty[s][i]  = (s == 0) ? WIDTH'(100) : WIDTH'($urandom_range(200, MAXV));
                src_phase[s][i] = WIDTH'($urandom_range(0, MAXV));
            end

        // Reset values, then first lane data one cycle after release
        repeat (3) @(negedge clk);
        chk("rst_duty", 64'(duty_out[0]), 64'd0);
        chk("rst_phase", 64'(phase_out[5]), 64'd0);
        chk("rst_cur_sel", 64'(cur_sel), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", 64'(done | err), 64'd0);
        rst = 1'b0;
        time_run = 1'b1;
        @(negedge clk);
        chk("duty_after_rst", 64'(duty_out[0]), 64'd100);
        chk("duty_after_rst_last", 64'(duty_out[DEPTH-1]), 64'd100);
        m_cur = 0;
        m_exp_last = 100;
        @(negedge clk);
        m_on = 1'b1;

        // Hard switch to source 1 lands on the 0x100 boundary
        push_duty(lane0(1, MAXV));
        ev_q.push_back('{1'b0, 1});
        m_cur = 1;
        wait_time(64'h00F);
        @(negedge clk);
        sel_req = 2'd1;
        ramp_step = '0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        wait_time(64'h0FF);
        #1 chk("cur_before_bnd", 64'(cur_sel), 64'd0);
        @(posedge clk);
        #1 chk("cur_at_bnd", 64'(cur_sel), 64'd1);
        chk("done_at_bnd", 64'(done), 64'd1);
        @(posedge clk);
        #1 chk("duty_after_swap", 64'(duty_out[0]), 64'(src_duty[1][0]));
        wait_settle();

        // Same source: immediate DONE; disabled source: ERR
        do_request(1, 1234, 1'b0);
        @(negedge clk);
        src_en = 4'b0111;
        do_request(3, 0, 1'b0);

        // Full ramp 8191 -> 4095 -> 0 -> swap -> 4096 -> 8191, with a request poked while busy
        @(negedge clk);
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) src_duty[s][i] = WIDTH'(MAXV);
        push_duty(lane0(m_cur, MAXV));
        wait_settle();
        do_request(0, 4096, 1'b1);

        // Reset in the middle of the down-ramp
        m_on = 1'b0;
        @(negedge clk);
        src_en = 4'hF;
        sel_req = 2'd1;
        ramp_step = WIDTH'(4096);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (duty_out[0] == WIDTH'(4095)) break;
            @(negedge clk);
        end
        if (k == 2000) fail_now("down_ramp_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cur_sel", 64'(cur_sel), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("midrst_limit_max", 64'(duty_out[0]), 64'(MAXV));
        repeat (600) @(negedge clk);
        m_cur = 0;
        m_exp_last = int'(duty_out[0]);
        wait_settle();
        m_on = 1'b1;

        // Randomized requests against the model
        for (int n = 0; n < 10; n++) begin
            new_scenario();
            sel = int'($urandom_range(0, 3));
            step = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2048, MAXV));
            do_request(sel, step, 1'b1);
        end

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        n_chk++;
        n_err++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
